// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data/IO memory: decodes lane enables,
// lane-replicated data and the target region at enqueue, then drains entries in order.
module store_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [1:0]  mem_sel,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    output logic        store_err,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] ST_SB = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SW = 2'd2;

    localparam logic [1:0] SEL_IOMEM = 2'd0;
    localparam logic [1:0] SEL_DMEM  = 2'd1;

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic          ready_en_reg;
    logic          store_err_reg, store_err_next;

    logic [1:0]  sel_mem   [DEPTH];
    logic [29:0] addr_mem  [DEPTH];
    logic [3:0]  we_mem    [DEPTH];
    logic [31:0] wdata_mem [DEPTH];

    logic [1:0]  sel_dec;
    logic [3:0]  we_dec;
    logic [31:0] wdata_dec;
    logic        region_err;
    logic        align_err;
    logic        st_err;

    logic          full;
    logic          accept;
    logic          enq;
    logic          deq;
    logic [AW-1:0] head;

    // Region decode from the top address nibble
    always_comb begin
        sel_dec    = SEL_IOMEM;
        region_err = 1'b0;
        case (st_addr[31:28])
            4'h1:    sel_dec = SEL_DMEM;
            4'h8:    sel_dec = SEL_IOMEM;
            default: region_err = 1'b1;
        endcase
    end

    always_comb begin
        we_dec    = 4'b0000;
        align_err = 1'b0;
        case (st_type)
            ST_SB: we_dec = 4'b0001 << st_addr[1:0];
            ST_SH: begin
                we_dec    = 4'b0011 << {st_addr[1], 1'b0};
                align_err = st_addr[0];
            end
            ST_SW: begin
                we_dec    = 4'b1111;
                align_err = |st_addr[1:0];
            end
            default: align_err = 1'b1;
        endcase
    end

    assign st_err = region_err | align_err;

    // Each byte lane picks its source byte so narrow stores land on any enabled lane
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_dec[8*gi +: 8] = (st_type == ST_SB) ? st_data[7:0] :
                                      (st_type == ST_SH) ? st_data[8*(gi%2) +: 8] :
                                                           st_data[8*gi +: 8];
    end

    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign st_ready = ready_en_reg & ~full;

    assign accept = st_valid & st_ready;
    assign enq    = accept & ~st_err;
    assign deq    = mem_req & mem_ack;

    assign wr_ptr_next    = wr_ptr_reg + PW'(enq);
    assign rd_ptr_next    = rd_ptr_reg + PW'(deq);
    assign store_err_next = accept & st_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ready_en_reg  <= 1'b0;
            store_err_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            ready_en_reg  <= 1'b1;
            store_err_reg <= store_err_next;
        end
    end

    // Entry payload needs no reset: validity is carried entirely by the pointers
    always_ff @(posedge clk) begin
        if (enq) begin
            sel_mem[wr_ptr_reg[AW-1:0]]   <= sel_dec;
            addr_mem[wr_ptr_reg[AW-1:0]]  <= st_addr[31:2];
            we_mem[wr_ptr_reg[AW-1:0]]    <= we_dec;
            wdata_mem[wr_ptr_reg[AW-1:0]] <= wdata_dec;
        end
    end

    assign head      = rd_ptr_reg[AW-1:0];
    assign mem_req   = ~empty;
    assign mem_sel   = sel_mem[head];
    assign mem_addr  = addr_mem[head];
    assign mem_we    = mem_req ? we_mem[head] : 4'b0000;
    assign mem_wdata = wdata_mem[head];
    assign store_err = store_err_reg;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the store rules.
module tb_store_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [1:0]  st_type = 2'd0;
    logic [31:0] st_addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [1:0]  mem_sel;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        store_err;
    logic        empty;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  sel;
        logic [29:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } wr_t;

    wr_t exp_q[$];

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_type   (st_type),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .store_err (store_err),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    // Reference: what memory write a store should become, or whether it is rejected
    function automatic bit ref_store(input logic [1:0] t, input logic [31:0] a,
                                     input logic [31:0] d, output wr_t w);
        bit err = 1'b0;
        int region;
        w = '0;
        region = int'(a >> 28);
        if (region == 1) w.sel = 2'd1;
        else if (region == 8) w.sel = 2'd0;
        else err = 1'b1;
        w.addr = 30'(a / 4);
        case (t)
            2'd0: begin
                w.we    = 4'(1 << (a % 4));
                w.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
            end
            2'd1: begin
                if (a % 2 != 0) err = 1'b1;
                w.we    = 4'(3 << (a % 4));
                w.wdata = {16'd0, d[15:0]} * 32'h0001_0001;
            end
            2'd2: begin
                if (a % 4 != 0) err = 1'b1;
                w.we    = 4'hF;
                w.wdata = d;
            end
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %0b expected 0", st_ready); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %0b expected 0", mem_req); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %0b expected 1", empty); end
        checks++; if (mem_we !== 4'h0) begin failures++; $display("FAIL rst_we: got %0h expected 0", mem_we); end
        checks++; if (store_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %0b expected 0", store_err); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL rel_ready_pre: got %0b expected 0", st_ready); end
        tick();
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL rel_ready_post: got %0b expected 1", st_ready); end
        $display("reset released, st_ready=%0b empty=%0b", st_ready, empty);
    endtask

    task automatic test_sb_example();
        st_valid = 1'b1; st_type = 2'd0; st_addr = 32'h1000_0003; st_data = 32'h0000_00A5; mem_ack = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sb_latency: got %0b expected 0", mem_req); end
        tick();
        st_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL sb_req: got %0b expected 1", mem_req); end
        checks++; if ({mem_sel, mem_addr, mem_we, mem_wdata} !== {2'd1, 30'h0400_0000, 4'b1000, 32'hA5A5_A5A5})
            begin failures++; $display("FAIL sb_fields: got sel=%0d addr=%h we=%b wdata=%h expected sel=1 addr=04000000 we=1000 wdata=a5a5a5a5", mem_sel, mem_addr, mem_we, mem_wdata); end
        $display("SB write sel=%0d addr=%h we=%b wdata=%h", mem_sel, mem_addr, mem_we, mem_wdata);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || mem_we !== 4'h0) begin failures++; $display("FAIL sb_drained: got empty=%0b we=%b expected empty=1 we=0000", empty, mem_we); end
    endtask

    task automatic test_sh_hold();
        st_valid = 1'b1; st_type = 2'd1; st_addr = 32'h8000_0012; st_data = 32'h0000_1234; mem_ack = 1'b0;
        tick();
        st_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({mem_req, mem_sel, mem_addr, mem_we, mem_wdata} !== {1'b1, 2'd0, 30'h2000_0004, 4'b1100, 32'h1234_1234})
                begin failures++; $display("FAIL sh_hold%0d: got req=%0b sel=%0d addr=%h we=%b wdata=%h expected req=1 sel=0 addr=20000004 we=1100 wdata=12341234", i, mem_req, mem_sel, mem_addr, mem_we, mem_wdata); end
            tick();
        end
        $display("SH write sel=%0d addr=%h we=%b wdata=%h", mem_sel, mem_addr, mem_we, mem_wdata);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sh_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_errors();
        logic [1:0]  typ [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
        logic [31:0] adr [4] = '{32'h1000_0002, 32'h4000_0000, 32'h8000_0001, 32'h1000_0000};
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_type = typ[i]; st_addr = adr[i]; st_data = $urandom();
            #1;
            checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL err%0d_ready_pre: got %0b expected 1", i, st_ready); end
            tick();
            st_valid = 1'b0;
            #1;
            checks++; if ({store_err, mem_req, st_ready} !== 3'b101)
                begin failures++; $display("FAIL err%0d_pulse: got err=%0b req=%0b ready=%0b expected err=1 req=0 ready=1", i, store_err, mem_req, st_ready); end
            $display("rejected store type=%0d addr=%h store_err=%0b", typ[i], adr[i], store_err);
            tick();
            checks++; if ({store_err, mem_req} !== 2'b00)
                begin failures++; $display("FAIL err%0d_after: got err=%0b req=%0b expected err=0 req=0", i, store_err, mem_req); end
        end
    endtask

    task automatic test_full();
        logic [31:0] d [3];
        for (int i = 0; i < 3; i++) d[i] = $urandom();
        mem_ack = 1'b0; st_valid = 1'b1; st_type = 2'd2;
        for (int i = 0; i < 2; i++) begin
            st_addr = 32'h1000_0100 + 32'(4*i); st_data = d[i];
            #1;
            checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL full_acc%0d: got %0b expected 1", i, st_ready); end
            tick();
        end
        st_addr = 32'h1000_0108; st_data = d[2];
        #1;
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %0b expected 0", st_ready); end
        tick();
        checks++; if (st_ready !== 1'b0 || mem_wdata !== d[0]) begin failures++; $display("FAIL full_stall: got ready=%0b wdata=%h expected ready=0 wdata=%h", st_ready, mem_wdata, d[0]); end
        mem_ack = 1'b1;
        #1;
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_no_bypass: got %0b expected 0", st_ready); end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++; if (st_ready !== 1'b1 || mem_wdata !== d[1]) begin failures++; $display("FAIL full_freed: got ready=%0b wdata=%h expected ready=1 wdata=%h", st_ready, mem_wdata, d[1]); end
        tick();
        st_valid = 1'b0; mem_ack = 1'b1;
        for (int i = 1; i < 3; i++) begin
            #1;
            checks++; if (mem_req !== 1'b1 || mem_wdata !== d[i] || mem_addr !== 30'(32'h0400_0040 + i))
                begin failures++; $display("FAIL full_order%0d: got req=%0b addr=%h wdata=%h expected req=1 addr=%h wdata=%h", i, mem_req, mem_addr, mem_wdata, 30'(32'h0400_0040 + i), d[i]); end
            $display("drain #%0d addr=%h wdata=%h", i, mem_addr, mem_wdata);
            tick();
        end
        mem_ack = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [10];
        int writes = 0;
        for (int i = 0; i < 10; i++) d[i] = $urandom();
        mem_ack = 1'b1; st_type = 2'd2;
        for (int i = 0; i < 12; i++) begin
            st_valid = (i < 10);
            st_addr  = 32'h1000_2000 + 32'(4*i);
            st_data  = (i < 10) ? d[i] : 32'd0;
            #1;
            checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d: got %0b expected 1", i, st_ready); end
            checks++; if (mem_req !== (i >= 1 && i <= 10)) begin failures++; $display("FAIL b2b_req%0d: got %0b expected %0b", i, mem_req, (i >= 1 && i <= 10)); end
            if (i >= 1 && i <= 10) begin
                checks++; if (mem_wdata !== d[i-1] || mem_addr !== 30'(32'h0400_0800 + i - 1))
                    begin failures++; $display("FAIL b2b_data%0d: got addr=%h wdata=%h expected addr=%h wdata=%h", i, mem_addr, mem_wdata, 30'(32'h0400_0800 + i - 1), d[i-1]); end
                $display("b2b write #%0d addr=%h wdata=%h", i - 1, mem_addr, mem_wdata);
            end
            if (mem_req === 1'b1) writes++;
            tick();
        end
        st_valid = 1'b0; mem_ack = 1'b0;
        #1;
        checks++; if (writes != 10 || empty !== 1'b1) begin failures++; $display("FAIL b2b_count: got writes=%0d empty=%0b expected writes=10 empty=1", writes, empty); end
    endtask

    task automatic test_random();
        wr_t  w;
        bit   err, acc, deq, exp_req;
        logic [31:0] r, a;
        logic [3:0]  region;
        int   nwr = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            r = $urandom();
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: region = 4'h1;
                5, 6, 7, 8:    region = 4'h8;
                default:       region = 4'($urandom_range(0, 15));
            endcase
            st_type  = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'd3;
            a = {region, r[27:0]};
            if ($urandom_range(0, 3) != 0) begin
                if (st_type == 2'd1) a[0] = 1'b0;
                if (st_type == 2'd2) a[1:0] = 2'b00;
            end
            st_addr  = a;
            st_data  = $urandom();
            st_valid = ($urandom_range(0, 9) < 7);
            mem_ack  = ($urandom_range(0, 9) < 5);
            #1;
            exp_req = (exp_q.size() != 0);
            checks++; if (mem_req !== exp_req || empty !== !exp_req)
                begin failures++; $display("FAIL rnd_req c%0d: got req=%0b empty=%0b expected req=%0b", cyc, mem_req, empty, exp_req); end
            checks++; if (st_ready !== (exp_q.size() < DEPTH))
                begin failures++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", cyc, st_ready, (exp_q.size() < DEPTH)); end
            checks++;
            if (exp_req) begin
                if ({mem_sel, mem_addr, mem_we, mem_wdata} !== exp_q[0])
                    begin failures++; $display("FAIL rnd_head c%0d: got %h expected %h", cyc, {mem_sel, mem_addr, mem_we, mem_wdata}, exp_q[0]); end
            end else if (mem_we !== 4'h0) begin
                failures++; $display("FAIL rnd_we_idle c%0d: got %b expected 0000", cyc, mem_we);
            end
            err = ref_store(st_type, st_addr, st_data, w);
            acc = st_valid && (exp_q.size() < DEPTH);
            deq = exp_req && mem_ack;
            tick();
            if (deq) begin
                $display("rnd write #%0d sel=%0d addr=%h we=%b wdata=%h", nwr, exp_q[0].sel, exp_q[0].addr, exp_q[0].we, exp_q[0].wdata);
                nwr++;
                void'(exp_q.pop_front());
            end
            if (acc && !err) exp_q.push_back(w);
            checks++; if (store_err !== (acc && err))
                begin failures++; $display("FAIL rnd_err c%0d: got %0b expected %0b", cyc, store_err, (acc && err)); end
        end
        st_valid = 1'b0; mem_ack = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 2 && exp_q.size() != 0; i++) begin
            #1;
            checks++; if (mem_req !== 1'b1 || mem_wdata !== exp_q[0].wdata)
                begin failures++; $display("FAIL rnd_drain%0d: got req=%0b wdata=%h expected req=1 wdata=%h", i, mem_req, mem_wdata, exp_q[0].wdata); end
            void'(exp_q.pop_front());
            tick();
        end
        mem_ack = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rnd_final_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_reset_mid_drain();
        mem_ack = 1'b0; st_valid = 1'b1; st_type = 2'd2;
        for (int i = 0; i < 2; i++) begin
            st_addr = 32'h1000_0300 + 32'(4*i); st_data = $urandom();
            tick();
        end
        st_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || st_ready !== 1'b0) begin failures++; $display("FAIL mid_pending: got req=%0b ready=%0b expected req=1 ready=0", mem_req, st_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_req, empty, st_ready, mem_we, store_err} !== {1'b0, 1'b1, 1'b0, 4'h0, 1'b0})
            begin failures++; $display("FAIL mid_async: got req=%0b empty=%0b ready=%0b we=%b err=%0b expected req=0 empty=1 ready=0 we=0000 err=0", mem_req, empty, st_ready, mem_we, store_err); end
        tick();
        tick();
        rst_n = 1'b1; mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (mem_req !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1)
                begin failures++; $display("FAIL mid_stale%0d: got req=%0b empty=%0b ready=%0b expected req=0 empty=1 ready=1", i, mem_req, empty, st_ready); end
        end
        mem_ack = 1'b0;
        $display("reset mid-drain done, empty=%0b", empty);
    endtask

    initial begin
        test_reset();
        test_sb_example();
        test_sh_hold();
        test_errors();
        test_full();
        test_back_to_back();
        test_random();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, FIFO entry count; power of two, >= 2.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port st_valid, input, 1, store request from MEM stage.
REQ-005 SHALL have port st_ready, output, 1, request accepted when st_valid & st_ready.
REQ-006 SHALL have port st_type, input, 2, encoding 0=SB, 1=SH, 2=SW; 3 is reserved.
REQ-007 SHALL have port st_addr, input, 32, byte address.
REQ-008 SHALL have port st_data, input, 32, unaligned store data, LSB-justified.
REQ-009 SHALL have port mem_req, output, 1, head entry valid toward memory.
REQ-010 SHALL have port mem_ack, input, 1, memory consumed head this cycle.
REQ-011 SHALL have port mem_sel, output, 2, target select: 0=IOMEM, 1=DMEM.
REQ-012 SHALL have port mem_addr, output, 30, word address, st_addr[31:2].
REQ-013 SHALL have port mem_we, output, 4, byte write enables.
REQ-014 SHALL have port mem_wdata, output, 32, lane-aligned write data.
REQ-015 SHALL have port store_err, output, 1, one-cycle pulse for a rejected store.
REQ-016 SHALL have port empty, output, 1, high when no entries are pending; used for fence and IO ordering.

Function
REQ-017 SHALL assert st_ready = !full and SHALL NOT bypass on a same-cycle dequeue when full.
REQ-018 SHALL apply the following SB lane rules: mem_we = 4'b0001 << addr[1:0], and st_data[7:0] is replicated into all 4 bytes of mem_wdata.
REQ-019 SHALL apply the following SH lane rules: mem_we = 4'b0011 << {addr[1],1'b0}, and st_data[15:0] is replicated into both halves of mem_wdata.
REQ-020 SHALL apply the following SW lane rules: mem_we = 4'b1111, and mem_wdata = st_data.
REQ-021 SHALL decode the region from st_addr[31:28]: 4'h1 selects DMEM (mem_sel=1), 4'h8 selects IOMEM (mem_sel=0), and every other value is a region error.
REQ-022 SHALL treat the following as errors: SH with addr[0]=1, SW with addr[1:0]!=0, st_type=3, or a region error.
REQ-023 SHALL consume an erroneous accepted request (handshake completes), SHALL NOT enqueue it, and SHALL pulse store_err high for exactly the next cycle.
REQ-024 SHALL register lane alignment, byte enables and target select at enqueue, and SHALL store them per entry.
REQ-025 SHALL drive mem_* directly from the head entry: mem_req = !empty.
REQ-026 SHALL hold mem_sel/addr/we/wdata stable while mem_req=1 and mem_ack=0.
REQ-027 SHALL dequeue on mem_req & mem_ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-028 SHALL use a latency of 1 cycle: a store accepted at edge N drives mem_req at N+1 at the earliest.
REQ-029 SHALL drain in FIFO order; write order to memory SHALL equal acceptance order.
REQ-030 SHALL use read/write pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
REQ-031 SHALL, on a simultaneous enqueue and dequeue when not full and not empty, keep occupancy unchanged.
REQ-032 SHALL, on a simultaneous enqueue and dequeue when empty, not dequeue, since mem_req=0.
REQ-033 SHALL drive mem_we=0 when mem_req=0.

Reset
REQ-034 SHALL, while rst_n=0, immediately and asynchronously force both pointers to 0, store_err=0, mem_req=0, mem_we=0 and empty=1.
REQ-035 SHALL, while rst_n=0, force st_ready=0.
REQ-036 SHALL drop all pending entries on reset mid-drain.
REQ-037 SHALL deassert reset synchronously to clk; st_ready SHALL go high on the first edge after release.

Verification
REQ-038 SB at 0x1000_0003, data 0x0000_00A5 -> next cycle mem_req=1, mem_sel=1, mem_addr=0x0400_0000, mem_we=4'b1000, mem_wdata=0xA5A5_A5A5.
REQ-039 SH at 0x8000_0012, data 0x1234, mem_ack held 0 for 3 cycles -> mem_sel=0, mem_we=4'b1100, mem_wdata=0x1234_1234, stable 3 cycles, dequeued on ack, empty=1.
REQ-040 SW at 0x1000_0002 -> store_err=1 for one cycle, mem_req stays 0, st_ready stays 1; repeat with SB at 0x4000_0000 -> same.
REQ-041 DEPTH=2, mem_ack=0, three back-to-back SW stores -> first two accepted, st_ready=0 on the third; one ack -> third accepted next cycle; drain order matches issue order.
REQ-042 Continuous st_valid and mem_ack=1 for 10 SW stores -> one write per cycle after 1-cycle latency, pointers wrap, no loss or duplication.
REQ-043 Assert rst_n=0 with 2 entries pending -> mem_req=0 and empty=1 without a clock edge; after release no stale writes appear.
